// File: rtl/id_ex_skid_reg_if.sv
// Handshake and payload bundle between decode (master) and the ID/EX skid
// register (slave); the EX-side outputs travel back on the same bundle.
interface id_ex_skid_reg_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 8
) ();
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic [ALUOP_W-1:0] ALUOp;
  logic               RegWrite;
  logic [DATA_W-1:0]  RsData;
  logic [DATA_W-1:0]  RtData;
  logic [FUNCT_W-1:0] Funct;
  logic [RADDR_W-1:0] Shamt;
  logic [RADDR_W-1:0] RdAddr;

  logic               out_valid;
  logic               out_ready;
  logic [ALUOP_W-1:0] ALUOpOut;
  logic               RegWriteOut;
  logic [DATA_W-1:0]  RsDataOut;
  logic [DATA_W-1:0]  RtDataOut;
  logic [FUNCT_W-1:0] FunctOut;
  logic [RADDR_W-1:0] ShamtOut;
  logic [RADDR_W-1:0] RdAddrOut;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output in_valid, flush, ALUOp, RegWrite, RsData, RtData, Funct, Shamt, RdAddr, out_ready,
    input  in_ready, out_valid, ALUOpOut, RegWriteOut, RsDataOut, RtDataOut, FunctOut,
           ShamtOut, RdAddrOut, stall_cnt
  );

  modport slave (
    input  in_valid, flush, ALUOp, RegWrite, RsData, RtData, Funct, Shamt, RdAddr, out_ready,
    output in_ready, out_valid, ALUOpOut, RegWriteOut, RsDataOut, RtDataOut, FunctOut,
           ShamtOut, RdAddrOut, stall_cnt
  );
endinterface

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with ready/valid handshake, 2-entry skid buffer,
// flush-to-bubble and a saturating stall counter.
module id_ex_skid_reg #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 8
) (
  input logic               clk,
  input logic               rst,
  id_ex_skid_reg_if.slave   bus
);
  localparam int PL_W = ALUOP_W + 1 + 2 * DATA_W + FUNCT_W + 2 * RADDR_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [PL_W-1:0]   r_main;
  logic [PL_W-1:0]   r_skid;
  logic [PL_W-1:0]   w_in_pl;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_drain;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;
  logic              w_head_rw;

  assign w_in_pl  = {bus.ALUOp, bus.RegWrite, bus.RsData, bus.RtData,
                     bus.Funct, bus.Shamt, bus.RdAddr};
  assign w_accept = bus.in_valid & w_in_ready;
  assign w_drain  = w_out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Flush overrides everything; a same-cycle drain is still treated as consumed.
  always_comb begin
    w_next_state     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (bus.flush) begin
      w_next_state = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_load_main_in = 1'b1;
            w_next_state   = S_ONE;
          end else begin
            w_next_state = S_EMPTY;
          end
        end
        S_ONE: begin
          if (w_accept && w_drain) begin
            w_load_main_in = 1'b1;
            w_next_state   = S_ONE;
          end else if (w_accept) begin
            w_load_skid  = 1'b1;
            w_next_state = S_FULL;
          end else if (w_drain) begin
            w_next_state = S_EMPTY;
          end else begin
            w_next_state = S_ONE;
          end
        end
        S_FULL: begin
          if (w_drain) begin
            w_load_main_skid = 1'b1;
            w_next_state     = S_ONE;
          end else begin
            w_next_state = S_FULL;
          end
        end
        default: begin
          w_next_state = S_EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    w_in_ready  = 1'b1;
    w_out_valid = 1'b0;
    case (r_state)
      S_EMPTY: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
      end
      S_ONE: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b1;
      end
      S_FULL: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b1;
      end
      default: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
      end
    endcase
    {bus.ALUOpOut, w_head_rw, bus.RsDataOut, bus.RtDataOut,
     bus.FunctOut, bus.ShamtOut, bus.RdAddrOut} = r_main;
    bus.in_ready    = w_in_ready;
    bus.out_valid   = w_out_valid;
    bus.RegWriteOut = w_head_rw & w_out_valid;
    bus.stall_cnt   = r_stall_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= {PL_W{1'b0}};
      r_skid <= {PL_W{1'b0}};
    end else begin
      if (w_load_main_in) begin
        r_main <= w_in_pl;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_pl;
      end
    end
  end

  // Counts EX back-pressure cycles, sticking at all-ones; flush does not clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (w_out_valid && !bus.out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Randomized and directed bench for id_ex_skid_reg, checked against a
// queue-based FIFO model with an unbounded stall tally.
module tb_id_ex_skid_reg;
  typedef struct packed {
    logic [1:0]  aluop;
    logic        rw;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rd;
  } pl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  pl_t  q[$];
  int   m_stall  = 0;
  int   exp_sat[6] = '{1, 2, 3, 3, 3, 3};

  always #5 clk = ~clk;

  id_ex_skid_reg_if #(.CNT_W(8)) bus ();
  id_ex_skid_reg_if #(.CNT_W(2)) bus2 ();

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.flush     = bus.flush;
  assign bus2.out_ready = bus.out_ready;
  assign bus2.ALUOp     = bus.ALUOp;
  assign bus2.RegWrite  = bus.RegWrite;
  assign bus2.RsData    = bus.RsData;
  assign bus2.RtData    = bus.RtData;
  assign bus2.Funct     = bus.Funct;
  assign bus2.Shamt     = bus.Shamt;
  assign bus2.RdAddr    = bus.RdAddr;

  id_ex_skid_reg #(.CNT_W(8)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  id_ex_skid_reg #(.CNT_W(2)) u_sat (.clk(clk), .rst(rst), .bus(bus2));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic pl_t mk(input logic [31:0] rs, input logic [5:0] f, input logic [4:0] rd);
    pl_t p;
    p.aluop = 2'd2;
    p.rw    = 1'b1;
    p.rs    = rs;
    p.rt    = ~rs;
    p.funct = f;
    p.shamt = 5'd3;
    p.rd    = rd;
    return p;
  endfunction

  function automatic pl_t rnd_pl();
    pl_t p;
    p.aluop = 2'($urandom);
    p.rw    = 1'($urandom);
    p.rs    = $urandom;
    p.rt    = $urandom;
    p.funct = 6'($urandom);
    p.shamt = 5'($urandom);
    p.rd    = 5'($urandom);
    return p;
  endfunction

  function automatic pl_t got_pl();
    pl_t p;
    p = {bus.ALUOpOut, bus.RegWriteOut, bus.RsDataOut, bus.RtDataOut,
         bus.FunctOut, bus.ShamtOut, bus.RdAddrOut};
    return p;
  endfunction

  task automatic check_outputs();
    logic exp_v;
    int   s8;
    int   s2;
    exp_v = (q.size() > 0);
    s8 = (m_stall > 255) ? 255 : m_stall;
    s2 = (m_stall > 3) ? 3 : m_stall;
    check("out_valid", 128'(bus.out_valid), 128'(exp_v));
    check("in_ready", 128'(bus.in_ready), 128'(q.size() < 2));
    check("rw_out", 128'(bus.RegWriteOut), exp_v ? 128'(q[0].rw) : 128'(0));
    if (exp_v) check("payload", 128'(got_pl()), 128'(q[0]));
    check("stall_cnt", 128'(bus.stall_cnt), 128'(s8));
    check("sat_cnt", 128'(bus2.stall_cnt), 128'(s2));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 128'(bus.out_valid), 128'(0));
    check({tag, "_ready"}, 128'(bus.in_ready), 128'(1));
    check({tag, "_rw"}, 128'(bus.RegWriteOut), 128'(0));
    check({tag, "_payload"}, 128'(got_pl()), 128'(0));
    check({tag, "_stall"}, 128'(bus.stall_cnt), 128'(0));
    check({tag, "_sat"}, 128'(bus2.stall_cnt), 128'(0));
  endtask

  // One clock: drive at negedge, advance the model, check after the posedge.
  task automatic step(input logic v, input logic fl, input logic ordy, input pl_t p);
    logic acc;
    logic drn;
    bus.in_valid  = v;
    bus.flush     = fl;
    bus.out_ready = ordy;
    bus.ALUOp     = p.aluop;
    bus.RegWrite  = p.rw;
    bus.RsData    = p.rs;
    bus.RtData    = p.rt;
    bus.Funct     = p.funct;
    bus.Shamt     = p.shamt;
    bus.RdAddr    = p.rd;
    acc = v && (q.size() < 2);
    drn = (q.size() > 0) && ordy;
    if ((q.size() > 0) && !ordy) m_stall++;
    if (fl) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(p);
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    pl_t idle;
    idle = '0;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    bus.ALUOp = '0; bus.RegWrite = 1'b0; bus.RsData = '0; bus.RtData = '0;
    bus.Funct = '0; bus.Shamt = '0; bus.RdAddr = '0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Streaming at full rate.
    step(1'b1, 1'b0, 1'b1, mk(32'h11, 6'h01, 5'd1)); check("t1_rs0", 128'(bus.RsDataOut), 128'(32'h11));
    step(1'b1, 1'b0, 1'b1, mk(32'h22, 6'h02, 5'd2)); check("t1_rs1", 128'(bus.RsDataOut), 128'(32'h22));
    step(1'b1, 1'b0, 1'b1, mk(32'h33, 6'h03, 5'd3)); check("t1_rs2", 128'(bus.RsDataOut), 128'(32'h33));
    step(1'b1, 1'b0, 1'b1, mk(32'h44, 6'h04, 5'd4)); check("t1_rs3", 128'(bus.RsDataOut), 128'(32'h44));
    step(1'b0, 1'b0, 1'b1, idle);
    check("t1_stall", 128'(bus.stall_cnt), 128'(0));

    // Back-pressure into the skid entry.
    step(1'b1, 1'b0, 1'b0, mk(32'h70, 6'h07, 5'd7));
    step(1'b1, 1'b0, 1'b0, mk(32'h90, 6'h09, 5'd9));
    step(1'b0, 1'b0, 1'b0, idle);
    step(1'b0, 1'b0, 1'b0, idle);
    check("t2_stall3", 128'(bus.stall_cnt), 128'(3));
    check("t2_hold7", 128'(bus.RdAddrOut), 128'(7));
    check("t2_full", 128'(bus.in_ready), 128'(0));
    step(1'b0, 1'b0, 1'b1, idle); check("t2_rd9", 128'(bus.RdAddrOut), 128'(9));
    step(1'b0, 1'b0, 1'b1, idle); check("t2_empty", 128'(bus.out_valid), 128'(0));

    // Flush while full with a new instruction offered.
    step(1'b1, 1'b0, 1'b0, mk(32'hA1, 6'h11, 5'd11));
    step(1'b1, 1'b0, 1'b0, mk(32'hA2, 6'h12, 5'd12));
    step(1'b1, 1'b1, 1'b0, mk(32'hA3, 6'h13, 5'd13));
    check("t3_valid", 128'(bus.out_valid), 128'(0));
    check("t3_rw", 128'(bus.RegWriteOut), 128'(0));
    check("t3_ready", 128'(bus.in_ready), 128'(1));
    step(1'b0, 1'b0, 1'b1, idle);

    // Accept and drain together in ONE.
    step(1'b1, 1'b0, 1'b1, mk(32'hB1, 6'h10, 5'd14));
    step(1'b1, 1'b0, 1'b1, mk(32'hB2, 6'h20, 5'd15));
    check("t4_funct", 128'(bus.FunctOut), 128'(6'h20));
    step(1'b0, 1'b0, 1'b1, idle);

    // Asynchronous reset between edges while FULL.
    step(1'b1, 1'b0, 1'b0, mk(32'hC1, 6'h21, 5'd16));
    step(1'b1, 1'b0, 1'b0, mk(32'hC2, 6'h22, 5'd17));
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset("areset");
    q.delete();
    m_stall = 0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b1, mk(32'h55, 6'h05, 5'd5));
    check("t6_first", 128'(bus.RsDataOut), 128'(32'h55));

    // Saturation on the 2-bit counter instance.
    step(1'b0, 1'b0, 1'b1, idle);
    step(1'b1, 1'b0, 1'b0, mk(32'h66, 6'h06, 5'd6));
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 1'b0, idle);
      check("t5_sat", 128'(bus2.stall_cnt), 128'(exp_sat[k]));
    end
    step(1'b0, 1'b0, 1'b1, idle);

    for (int n = 0; n < 2000; n++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 6, rnd_pl());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
